intersection_request_frontend: RTL and testbench
================================================

// Module: intersection_request_frontend
// PURPOSE
// - Upstream front end for the intersection controller: conditions raw field inputs into
//   the controller's pedestrian_button / turn_sensor request inputs.
// - Holds each request until the controller acknowledges it by asserting the matching
//   green (pedestrian_green / turn_green), closing the request/serve loop.
// - Sits between the pad ring (async button, inductive loop sensor) and the controller.
// PARAMETERS
// - DEBOUNCE_CYCLES  4   consecutive stable cycles before a debounced level changes (>=1)
// - ARRIVAL_CYCLES   8   cycles of continuous presence before a turn request is raised (>=1)
// - ABANDON_CYCLES   64  cycles of continuous absence that drop an unserved turn request (>=1)
// PORTS
// - clock              in   1  system clock
// - reset              in   1  synchronous, active-low reset
// - ped_button_raw     in   1  asynchronous pedestrian push button, active-high
// - turn_presence_raw  in   1  asynchronous turn-lane loop sensor, active-high
// - pedestrian_green   in   1  controller acknowledge: pedestrian phase active
// - turn_green         in   1  controller acknowledge: turn phase active
// - pedestrian_button  out  1  latched pedestrian request to controller (also drives wait lamp)
// - turn_sensor        out  1  qualified, latched turn request to controller
// BEHAVIOUR
// - Reset (reset==0 at a clock edge): all sync flops, debounced levels, counters = 0; turn
//   FSM = IDLE; pedestrian_button = 0, turn_sensor = 0. Reset mid-request discards it.
// - Each raw input: 2-flop synchroniser, then debouncer. Debounce counter counts consecutive
//   cycles sync!=deb; clears when sync==deb; deb<=sync when count reaches DEBOUNCE_CYCLES.
//   Glitches shorter than DEBOUNCE_CYCLES cycles never change deb.
// - All outputs registered. Raw rise first sampled at edge t -> deb rises at t+2+DEBOUNCE_CYCLES.
// - Pedestrian latch: set on deb rising edge; cleared in any cycle pedestrian_green==1.
//   Set and clear in the same cycle: clear wins (press during green is ignored, not queued).
//   Further presses while latched: no effect. pedestrian_button rises DEBOUNCE_CYCLES+3
//   clocks after t (7 at default).
// - Turn FSM (on debounced presence p; counter cnt is 0 on every state entry):
//   IDLE:     p==1 -> ARRIVING.
//   ARRIVING: p==0 -> IDLE; cnt counts cycles in state with p==1; p==1 and
//             cnt==ARRIVAL_CYCLES-1 -> WAITING.
//   WAITING:  turn_sensor=1. turn_green==1 -> SERVED (priority over abandon);
//             cnt counts consecutive p==0 cycles, clears on p==1;
//             cnt reaches ABANDON_CYCLES -> IDLE.
//   SERVED:   turn_sensor=0; turn_green==0 -> IDLE (queued vehicle must re-qualify).
//   turn_sensor is 1 exactly in WAITING (registered from next-state decode).
// - turn_green==1 outside WAITING: no effect. pedestrian_green/turn_green used unsynchronised
//   (same clock domain as controller).
// - Counter width $clog2(max(DEBOUNCE_CYCLES,ARRIVAL_CYCLES,ABANDON_CYCLES)+1); counters
//   saturate, never wrap.
// STRUCTURE
// - intersection_pkg: turn_state_t enum {IDLE, ARRIVING, WAITING, SERVED}; default values
//   of the three timing constants.
// - Sub-module input_debouncer (sync + debounce, param DEBOUNCE_CYCLES), instantiated twice;
//   pedestrian latch and turn FSM in this module.
// TESTING
// - Reset: hold reset=0 3 cycles with both raw inputs 1 -> both outputs 0, FSM IDLE throughout.
// - Press: ped_button_raw high from edge 10 -> pedestrian_button 1 at edge 17; release at 12,
//   stays 1; pedestrian_green pulse at 30 -> 0 at edge 31.
// - Glitch: ped_button_raw high 3 cycles, turn_presence_raw low-glitch 3 cycles in WAITING ->
//   no output change, abandon counter cleared.
// - Press during green: pedestrian_green=1 while deb rises -> pedestrian_button stays 0.
// - Turn: presence held -> turn_sensor 1 at DEBOUNCE_CYCLES+ARRIVAL_CYCLES+3 (15) after first
//   sample; turn_green 1 -> 0 next edge; presence held past turn_green fall -> re-request
//   after ARRIVAL_CYCLES+1 more cycles.
// - Abandon: WAITING, presence drops for 64 debounced cycles -> turn_sensor 0; at 63 then
//   return -> stays 1.

Source files
------------

// File: rtl/intersection_pkg.sv
// intersection_pkg
// Shared types and default timing constants for the intersection request front end.
// - turn_state_t : states of the turn-lane request FSM
// - DEFAULT_*    : default cycle counts for debounce, arrival qualification and abandon
// - max3         : helper used to size the shared counter width
package intersection_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARRIVING = 2'd1,
    WAITING  = 2'd2,
    SERVED   = 2'd3
  } turn_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_ARRIVAL_CYCLES  = 8;
  localparam int DEFAULT_ABANDON_CYCLES  = 64;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// input_debouncer
// Two-flop synchroniser followed by a counting debouncer for one asynchronous input.
// Ports:
//   clock  in   system clock
//   reset  in   synchronous, active-low reset
//   raw    in   asynchronous field input
//   level  out  debounced, registered level
// The debounced level only follows the synchronised input once it has differed from
// the current level for DEBOUNCE_CYCLES consecutive cycles.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  logic             sync_meta;
  logic             sync_q;
  logic [CNT_W-1:0] stable_cnt;

  // Synchronise the raw input, then count consecutive cycles in which it disagrees
  // with the debounced level. Any agreement restarts the count, so short glitches
  // are absorbed. The counter saturates rather than wrapping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_meta  <= 1'b0;
      sync_q     <= 1'b0;
      stable_cnt <= '0;
      level      <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      if (sync_q == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        level      <= sync_q;
        stable_cnt <= '0;
      end else if (stable_cnt != '1) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/intersection_request_frontend.sv
// intersection_request_frontend
// Conditions raw field inputs into latched requests for the intersection controller
// and holds each request until the controller grants the matching green.
// Ports:
//   clock              in   system clock
//   reset              in   synchronous, active-low reset
//   ped_button_raw     in   asynchronous pedestrian push button
//   turn_presence_raw  in   asynchronous turn-lane loop sensor
//   pedestrian_green   in   controller acknowledge, pedestrian phase active
//   turn_green         in   controller acknowledge, turn phase active
//   pedestrian_button  out  latched pedestrian request (also drives wait lamp)
//   turn_sensor        out  qualified, latched turn request
module intersection_request_frontend
  import intersection_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ARRIVAL_CYCLES  = DEFAULT_ARRIVAL_CYCLES,
  parameter int ABANDON_CYCLES  = DEFAULT_ABANDON_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic ped_button_raw,
  input  logic turn_presence_raw,
  input  logic pedestrian_green,
  input  logic turn_green,
  output logic pedestrian_button,
  output logic turn_sensor
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, ARRIVAL_CYCLES, ABANDON_CYCLES) + 1);

  logic             ped_level;
  logic             ped_level_q;
  logic             presence;
  turn_state_t      turn_state;
  turn_state_t      turn_state_next;
  logic [CNT_W-1:0] turn_cnt;
  logic [CNT_W-1:0] turn_cnt_next;

  input_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ped_debouncer (
    .clock (clock),
    .reset (reset),
    .raw   (ped_button_raw),
    .level (ped_level)
  );

  input_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_turn_debouncer (
    .clock (clock),
    .reset (reset),
    .raw   (turn_presence_raw),
    .level (presence)
  );

  // Pedestrian latch: a debounced press sets it, the pedestrian green clears it.
  // Clear has priority so a press made during the green is dropped, not queued.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ped_level_q       <= 1'b0;
      pedestrian_button <= 1'b0;
    end else begin
      ped_level_q <= ped_level;
      if (pedestrian_green) begin
        pedestrian_button <= 1'b0;
      end else if (ped_level && !ped_level_q) begin
        pedestrian_button <= 1'b1;
      end
    end
  end

  // Turn FSM state, shared counter and registered request output. The output is
  // decoded from the next state so it changes on the same edge as the state.
  always_ff @(posedge clock) begin
    if (!reset) begin
      turn_state  <= IDLE;
      turn_cnt    <= '0;
      turn_sensor <= 1'b0;
    end else begin
      turn_state  <= turn_state_next;
      turn_cnt    <= turn_cnt_next;
      turn_sensor <= (turn_state_next == WAITING);
    end
  end

  // Next-state logic. The counter is zeroed on every transition; in ARRIVING it
  // counts qualified presence cycles, in WAITING it counts consecutive absence.
  always_comb begin
    turn_state_next = turn_state;
    turn_cnt_next   = '0;
    case (turn_state)
      IDLE: begin
        if (presence) turn_state_next = ARRIVING;
      end
      ARRIVING: begin
        if (!presence) begin
          turn_state_next = IDLE;
        end else if (turn_cnt == CNT_W'(ARRIVAL_CYCLES - 1)) begin
          turn_state_next = WAITING;
        end else begin
          turn_cnt_next = (turn_cnt == '1) ? turn_cnt : turn_cnt + 1'b1;
        end
      end
      WAITING: begin
        if (turn_green) begin
          turn_state_next = SERVED;
        end else if (presence) begin
          turn_cnt_next = '0;
        end else if (turn_cnt == CNT_W'(ABANDON_CYCLES - 1)) begin
          turn_state_next = IDLE;
        end else begin
          turn_cnt_next = (turn_cnt == '1) ? turn_cnt : turn_cnt + 1'b1;
        end
      end
      SERVED: begin
        if (!turn_green) turn_state_next = IDLE;
      end
      default: begin
        turn_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_intersection_request_frontend.sv
// tb_intersection_request_frontend
// Directed, self-checking bench for intersection_request_frontend at default timing.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_intersection_request_frontend;
  import intersection_pkg::*;

  logic clock;
  logic reset;
  logic ped_button_raw;
  logic turn_presence_raw;
  logic pedestrian_green;
  logic turn_green;
  logic pedestrian_button;
  logic turn_sensor;

  int errors;
  int checks;

  intersection_request_frontend dut (
    .clock             (clock),
    .reset             (reset),
    .ped_button_raw    (ped_button_raw),
    .turn_presence_raw (turn_presence_raw),
    .pedestrian_green  (pedestrian_green),
    .turn_green        (turn_green),
    .pedestrian_button (pedestrian_button),
    .turn_sensor       (turn_sensor)
  );

  // Free-running clock, 10 time units per period
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive all four functional inputs at once
  task automatic applyStimulus(input logic ped, input logic turn, input logic pg, input logic tg);
    ped_button_raw    = ped;
    turn_presence_raw = turn;
    pedestrian_green  = pg;
    turn_green        = tg;
  endtask

  // Advance n rising edges and settle 1 time unit past the last one
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One comparison: counts it, and reports and counts a failure
  task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // Reset held 3 cycles with both raw inputs high: nothing may come out
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      checkOutput("reset_ped", {1'b0, pedestrian_button}, 2'd0);
      checkOutput("reset_turn", {1'b0, turn_sensor}, 2'd0);
      checkOutput("reset_state", 2'(dut.turn_state), 2'(IDLE));
    end

    // Release reset with both inputs held: ped request after 7 edges, turn after 15
    reset = 1'b1;
    step(7);
    checkOutput("ped_before_7", {1'b0, pedestrian_button}, 2'd0);
    step(1);
    checkOutput("ped_at_7", {1'b0, pedestrian_button}, 2'd1);
    checkOutput("turn_before_15a", {1'b0, turn_sensor}, 2'd0);
    step(7);
    checkOutput("turn_before_15", {1'b0, turn_sensor}, 2'd0);
    step(1);
    checkOutput("turn_at_15", {1'b0, turn_sensor}, 2'd1);

    // Button released: request remains latched
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(10);
    checkOutput("ped_held", {1'b0, pedestrian_button}, 2'd1);

    // One-cycle pedestrian green clears the latch on that edge
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    step(1);
    checkOutput("ped_cleared", {1'b0, pedestrian_button}, 2'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(4);
    checkOutput("ped_stays_clear", {1'b0, pedestrian_button}, 2'd0);

    // 3-cycle glitches: button high, presence low while WAITING
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(12);
    checkOutput("glitch_ped", {1'b0, pedestrian_button}, 2'd0);
    checkOutput("glitch_turn", {1'b0, turn_sensor}, 2'd1);

    // Presence gone for 63 debounced cycles then back: request survives
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(63);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) begin
      step(1);
      checkOutput("abandon_63", {1'b0, turn_sensor}, 2'd1);
    end

    // Presence gone for 64 debounced cycles: request dropped on the 64th
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(70);
    checkOutput("abandon_before_64", {1'b0, turn_sensor}, 2'd1);
    step(1);
    checkOutput("abandon_at_64", {1'b0, turn_sensor}, 2'd0);
    checkOutput("abandon_state", 2'(dut.turn_state), 2'(IDLE));

    // Fresh arrival, serve with turn_green, then re-qualify while presence is held
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(15);
    checkOutput("arrive_before_15", {1'b0, turn_sensor}, 2'd0);
    step(1);
    checkOutput("arrive_at_15", {1'b0, turn_sensor}, 2'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    step(1);
    checkOutput("served_drop", {1'b0, turn_sensor}, 2'd0);
    step(3);
    checkOutput("served_hold", {1'b0, turn_sensor}, 2'd0);
    checkOutput("served_state", 2'(dut.turn_state), 2'(SERVED));
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(9);
    checkOutput("requal_before_9", {1'b0, turn_sensor}, 2'd0);
    step(1);
    checkOutput("requal_at_9", {1'b0, turn_sensor}, 2'd1);

    // Press whose debounced rise lands while pedestrian green is high: ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step(6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    step(3);
    checkOutput("press_in_green", {1'b0, pedestrian_button}, 2'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step(5);
    checkOutput("press_in_green_after", {1'b0, pedestrian_button}, 2'd0);

    // Latched request discarded by a mid-request reset
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(10);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step(8);
    checkOutput("ped_relatched", {1'b0, pedestrian_button}, 2'd1);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step(1);
    checkOutput("midreset_ped", {1'b0, pedestrian_button}, 2'd0);
    checkOutput("midreset_turn", {1'b0, turn_sensor}, 2'd0);
    reset = 1'b1;
    step(20);
    checkOutput("midreset_ped_after", {1'b0, pedestrian_button}, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
